// File: rtl/seg7_msg_sequencer.sv
// seg7_msg_sequencer: steps a stored message of character codes onto one
// 7-segment display. Each character is shown for DWELL cycles and is followed
// by GAP blank cycles. The run can stop at the end or loop back to the start.
// Optional build macro SEG_DOT_EN: lights the dot (SEG[7]) while the last
// character of the message is shown.
module seg7_msg_sequencer #(
    parameter int MSG_DEPTH = 16,
    parameter int CODE_W    = 6,
    parameter int DWELL     = 2,
    parameter int GAP       = 1,
    localparam int AW       = $clog2(MSG_DEPTH)
) (
    input  logic              clk_2,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CODE_W-1:0] wr_code,
    input  logic [AW:0]       msg_len,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     char_idx,
    output logic [7:0]        SEG
);

    localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [AW:0]      DEPTH_L    = (AW + 1)'(MSG_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     idx, idx_nxt;
    logic [AW:0]       len_q, len_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              done_nxt;
    logic              adv;
    logic [CODE_W-1:0] msg_buf [MSG_DEPTH];

    // Character code to gfedcba segment pattern; unknown codes show a dash.
    function automatic logic [6:0] decode(input logic [CODE_W-1:0] code);
        logic [6:0] s;
        case (int'(code))
            0:  s = 7'h3F;  1:  s = 7'h06;  2:  s = 7'h5B;  3:  s = 7'h4F;
            4:  s = 7'h66;  5:  s = 7'h6D;  6:  s = 7'h7D;  7:  s = 7'h07;
            8:  s = 7'h7F;  9:  s = 7'h6F;  10: s = 7'h77;  11: s = 7'h7C;
            12: s = 7'h39;  13: s = 7'h5E;  14: s = 7'h79;  15: s = 7'h71;
            16: s = 7'h77;  // A
            17: s = 7'h7C;  // b
            18: s = 7'h39;  // C
            19: s = 7'h58;  // c
            20: s = 7'h5E;  // d
            21: s = 7'h79;  // E
            22: s = 7'h71;  // F
            23: s = 7'h6F;  // g
            24: s = 7'h76;  // H
            25: s = 7'h74;  // h
            26: s = 7'h30;  // I
            27: s = 7'h10;  // i
            28: s = 7'h1E;  // J
            29: s = 7'h38;  // L
            30: s = 7'h54;  // n
            31: s = 7'h3F;  // O
            32: s = 7'h5C;  // o
            33: s = 7'h73;  // P
            34: s = 7'h67;  // q
            35: s = 7'h50;  // r
            36: s = 7'h6D;  // S
            37: s = 7'h78;  // t
            38: s = 7'h3E;  // U
            39: s = 7'h1C;  // u
            40: s = 7'h6E;  // y
            41: s = 7'h63;  // degree
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Message buffer: writable in every state, cleared by reset.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_DEPTH; i++) msg_buf[i] <= '0;
        end else if (wr_en) begin
            msg_buf[wr_addr] <= wr_code;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            len_q <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            len_q <= len_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state logic; the dwell/gap counter restarts on every state entry,
    // including SHOW->SHOW when there is no gap.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        len_nxt   = len_q;
        cnt_nxt   = cnt + 1'b1;
        done_nxt  = 1'b0;
        adv       = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (start && !stop && msg_len != '0) begin
                    state_nxt = S_SHOW;
                    idx_nxt   = '0;
                    len_nxt   = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
                end
            end
            S_SHOW: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (cnt == DWELL_LAST) begin
                    if (GAP > 0) begin
                        state_nxt = S_GAP;
                        cnt_nxt   = '0;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (cnt == GAP_LAST) begin
                    adv = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (adv) begin
            cnt_nxt = '0;
            if ({1'b0, idx} < len_q - (AW + 1)'(1)) begin
                idx_nxt   = idx + 1'b1;
                state_nxt = S_SHOW;
            end else if (loop_en) begin
                idx_nxt   = '0;
                state_nxt = S_SHOW;
            end else begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end
        end
    end

    assign busy     = (state != S_IDLE);
    assign char_idx = idx;
    assign SEG[6:0] = (state == S_SHOW) ? decode(msg_buf[idx]) : 7'd0;
`ifdef SEG_DOT_EN
    assign SEG[7]   = (state == S_SHOW) && ({1'b0, idx} == len_q - (AW + 1)'(1));
`else
    assign SEG[7]   = 1'b0;
`endif

endmodule

// File: doc/seg7_msg_sequencer.md
Name: seg7_msg_sequencer

Overview:
- Sequences a stored message of 6-bit character codes onto the single 7-segment display, one character at a time.
- Each character is shown for a programmable dwell, followed by an optional blank gap.
- A small write port loads the message buffer; start/stop control the run, with optional looping.
- Sits between the switch/LED top level and the SEG output.

Parameters:
- MSG_DEPTH, 16, number of character slots in the message buffer (power of 2).
- CODE_W, 6, width of a character code.
- DWELL, 2, clk_2 cycles each character is displayed (must be ≥1).
- GAP, 1, clk_2 cycles of blank display after each character (0 = no gap).

Ports:
- clk_2  input  1  system clock
- rst_n  input  1  asynchronous reset, active-low
- wr_en  input  1  write wr_code into buffer[wr_addr] at the clock edge
- wr_addr  input  log2(MSG_DEPTH)  buffer write address
- wr_code  input  CODE_W  character code to store
- msg_len  input  log2(MSG_DEPTH)+1  message length; sampled on an accepted start
- start  input  1  begin display run (level, sampled each cycle)
- stop  input  1  abort run
- loop_en  input  1  restart at character 0 after the last character instead of finishing
- busy  output  1  high while in SHOW or GAP
- done  output  1  one-cycle pulse when a non-looping run completes
- char_idx  output  log2(MSG_DEPTH)  index of the character currently sequenced
- SEG  output  8  segment drive; SEG[6:0]=gfedcba, SEG[7]=dot

Behaviour:
- Asynchronous reset (rst_n=0):
  - state=IDLE; idx=0; len_q=0; all buffer entries=0.
  - Outputs: SEG=0, busy=0, done=0, char_idx=0.
- Character decode (combinational, team standard table):
  - Codes 0–15: hex digits (0→0111111, 1→0000110 … F→1110001).
  - Codes 16–41: letters A b C c d E F g H h I i J L n O o P q r S t U u y °.
  - All other codes → 1000000 (dash).
- SEG[6:0] is a combinational function of registered state, idx and buffer; there is no added pipeline latency.
  - SHOW: decode(buffer[idx]).
  - IDLE and GAP: 0000000.
- States and transitions:
  - IDLE: busy=0. When start=1, stop=0 and msg_len≠0: len_q=min(msg_len,MSG_DEPTH), idx=0, go to SHOW. Otherwise remain in IDLE; start is ignored when msg_len=0.
  - SHOW: counts DWELL cycles. Then go to GAP if GAP>0; otherwise take the advance step directly.
  - GAP: counts GAP cycles, then takes the advance step.
  - Advance step:
    - If idx<len_q-1: idx+1, go to SHOW.
    - Else if loop_en=1 (sampled at this point): idx=0, go to SHOW.
    - Else: go to IDLE with done=1 during the first IDLE cycle.
- stop=1 in SHOW or GAP: IDLE on the next edge, idx=0, no done pulse.
- stop and start in the same cycle: stop wins.
- start while busy: ignored; msg_len changes during a run are ignored.
- Buffer writes are allowed in any state.
  - A write to buffer[idx] during SHOW changes SEG from the next cycle.
  - wr_en and start in the same cycle: the written value is used for the run.
- Dwell/gap counter resets on every state entry. The counter is wide enough for max(DWELL,GAP).
- char_idx=idx at all times.

Optional Feature:
- Macro: SEG_DOT_EN.
- Defined: SEG[7]=1 while in SHOW on the last character (idx=len_q-1); 0 otherwise.
- Not defined: SEG[7]=0 constantly and no extra logic.

Test Plan:
- Reset: rst_n=0 mid-operation → same cycle SEG=00000000, busy=0, done=0, char_idx=0. After release, start with msg_len=1 → SEG=00111111 (buffer cleared to code 0).
- Non-looping run (DWELL=2, GAP=1): write codes 33,16,22 at addresses 0–2; msg_len=3, loop_en=0; pulse start.
  - SEG sequence: 1110011 ×2, 0 ×1, 1110111 ×2, 0, 1110001 ×2, 0.
  - Then done=1 for 1 cycle; busy high exactly 9 cycles.
- Looping run: msg_len=2, loop_en=1 → after idx=1 gap, char_idx returns to 0 with no done. Assert stop during SHOW → next cycle IDLE, SEG=0, done stays 0.
- Boundaries:
  - Code 50 stored → SEG[6:0]=1000000.
  - start with msg_len=0 → busy stays 0.
  - msg_len=20 → run covers 16 characters, char_idx wraps 15→done.
- Simultaneous events:
  - start+stop in IDLE → stays IDLE.
  - wr_en to address 0 (code 1) with start → first SEG=0000110.
  - start while busy → no restart, char_idx unaffected.
- Dot feature: compile with SEG_DOT_EN, run the P,A,F message → SEG[7]=1 only during the two cycles showing F. Compile without → SEG[7]=0 throughout.
